// File: rtl/seven_seg_capture_if.sv
// Segment-bus / digit-select link between a 2-digit 7-segment driver and its capture monitor.
interface seven_seg_capture_if;
    logic [6:0]  seg_in;
    logic        sel_in;
    logic [13:0] both7seg_out;
    logic [3:0]  digit_hi;
    logic [3:0]  digit_lo;
    logic        hi_valid;
    logic        lo_valid;
    logic        update;
    logic        stale;

    modport master (
        output seg_in, sel_in,
        input  both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid, update, stale
    );

    modport slave (
        input  seg_in, sel_in,
        output both7seg_out, digit_hi, digit_lo, hi_valid, lo_valid, update, stale
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed two-digit 7-segment bus, rebuilds the {hi,lo} pattern word and
// publishes it once it has been stable for STABLE_FRAMES frames; also decodes digits and flags a dead select.
module seven_seg_capture #(
    parameter int unsigned SETTLE        = 2,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned TBITS         = 11
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_capture_if.slave bus
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);

    typedef enum logic {ST_WAIT, ST_SETTLE} state_t;

    // Returns {valid, nibble}; unknown glyphs decode to nibble 0, valid 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [6:0]      seg_m_q, seg_m_d, seg_s_q, seg_s_d;
    logic            sel_m_q, sel_m_d, sel_s_q, sel_s_d, sel_d_q, sel_d_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [6:0]      hi_pat_q, hi_pat_d;
    logic            have_hi_q, have_hi_d;
    logic [13:0]     cand_q, cand_d;
    logic [MW-1:0]   match_q, match_d;
    logic [TBITS-1:0] timer_q, timer_d;
    logic [13:0]     out_q, out_d;
    logic [3:0]      dig_hi_q, dig_hi_d, dig_lo_q, dig_lo_d;
    logic            hv_q, hv_d, lv_q, lv_d;
    logic            update_q, update_d;
    logic            stale_q, stale_d;

    logic            sel_edge;
    logic            sample;
    logic            frame_done;
    logic [13:0]     frame;

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        hi_pat_d   = hi_pat_q;
        have_hi_d  = have_hi_q;
        cand_d     = cand_q;
        match_d    = match_q;
        timer_d    = timer_q;
        out_d      = out_q;
        update_d   = 1'b0;
        sample     = 1'b0;
        frame_done = 1'b0;

        // Two-flop synchronisers plus one extra select delay for edge detection.
        seg_m_d  = bus.seg_in;
        seg_s_d  = seg_m_q;
        sel_m_d  = bus.sel_in;
        sel_s_d  = sel_m_q;
        sel_d_d  = sel_s_q;
        sel_edge = (sel_s_q != sel_d_q);
        frame    = {hi_pat_q, seg_s_q};

        case (state_q)
            ST_WAIT: begin
                if (sel_edge) begin
                    state_d = ST_SETTLE;
                    scnt_d  = SW'(1);
                end
            end
            ST_SETTLE: begin
                if (sel_edge) begin
                    scnt_d = SW'(1);
                end else if (scnt_q == SW'(SETTLE)) begin
                    sample  = 1'b1;
                    state_d = ST_WAIT;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // A lo sample only closes a frame if a hi sample preceded it.
        if (sample) begin
            if (sel_s_q) begin
                hi_pat_d  = seg_s_q;
                have_hi_d = 1'b1;
            end else if (have_hi_q) begin
                frame_done = 1'b1;
                have_hi_d  = 1'b0;
            end
        end

        if (frame_done) begin
            if (frame == cand_q) begin
                if (match_q < MW'(STABLE_FRAMES))
                    match_d = match_q + MW'(1);
            end else begin
                cand_d  = frame;
                match_d = MW'(1);
            end
            if ((match_d == MW'(STABLE_FRAMES)) && (cand_d != out_q)) begin
                out_d    = cand_d;
                update_d = 1'b1;
            end
        end

        // Decode follows the next published word so it lines up with both7seg_out.
        {hv_d, dig_hi_d} = seg_decode(out_d[13:7]);
        {lv_d, dig_lo_d} = seg_decode(out_d[6:0]);

        if (sel_edge)
            timer_d = '0;
        else if (timer_q != TBITS'(TIMEOUT))
            timer_d = timer_q + TBITS'(1);
        stale_d = (timer_q == TBITS'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            seg_m_q   <= '0;
            seg_s_q   <= '0;
            sel_m_q   <= 1'b0;
            sel_s_q   <= 1'b0;
            sel_d_q   <= 1'b0;
            scnt_q    <= '0;
            hi_pat_q  <= '0;
            have_hi_q <= 1'b0;
            cand_q    <= '0;
            match_q   <= '0;
            timer_q   <= '0;
            out_q     <= '0;
            dig_hi_q  <= '0;
            dig_lo_q  <= '0;
            hv_q      <= 1'b0;
            lv_q      <= 1'b0;
            update_q  <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_m_q   <= seg_m_d;
            seg_s_q   <= seg_s_d;
            sel_m_q   <= sel_m_d;
            sel_s_q   <= sel_s_d;
            sel_d_q   <= sel_d_d;
            scnt_q    <= scnt_d;
            hi_pat_q  <= hi_pat_d;
            have_hi_q <= have_hi_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
            timer_q   <= timer_d;
            out_q     <= out_d;
            dig_hi_q  <= dig_hi_d;
            dig_lo_q  <= dig_lo_d;
            hv_q      <= hv_d;
            lv_q      <= lv_d;
            update_q  <= update_d;
            stale_q   <= stale_d;
        end
    end

    assign bus.both7seg_out = out_q;
    assign bus.digit_hi     = dig_hi_q;
    assign bus.digit_lo     = dig_lo_q;
    assign bus.hi_valid     = hv_q;
    assign bus.lo_valid     = lv_q;
    assign bus.update       = update_q;
    assign bus.stale        = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: stimulus queues expected published words,
// a negedge monitor pops and checks them on every update pulse.
module tb_seven_seg_capture;

    localparam int HALF = 30;

    typedef struct {
        logic [13:0] w;
        logic [3:0]  dh;
        logic [3:0]  dl;
        logic        hv;
        logic        lv;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    seven_seg_capture_if bus ();

    seven_seg_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [13:0] w, input logic [3:0] dh, input logic [3:0] dl,
                        input logic hv, input logic lv);
        exp_t e;
        e.w = w; e.dh = dh; e.dl = dl; e.hv = hv; e.lv = lv;
        q.push_back(e);
    endtask

    task automatic frame(input logic [6:0] h, input logic [6:0] l);
        bus.sel_in = 1'b1; bus.seg_in = h; cyc(HALF);
        bus.sel_in = 1'b0; bus.seg_in = l; cyc(HALF);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk({name, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_word"},   32'(bus.both7seg_out), 32'd0);
        chk({tag, "_dhi"},    32'(bus.digit_hi),     32'd0);
        chk({tag, "_dlo"},    32'(bus.digit_lo),     32'd0);
        chk({tag, "_hv"},     32'(bus.hi_valid),     32'd0);
        chk({tag, "_lv"},     32'(bus.lo_valid),     32'd0);
        chk({tag, "_update"}, 32'(bus.update),       32'd0);
        chk({tag, "_stale"},  32'(bus.stale),        32'd0);
    endtask

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && bus.update === 1'b1) begin
            chk("update_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("word",     32'(bus.both7seg_out), 32'(e.w));
                chk("digit_hi", 32'(bus.digit_hi),     32'(e.dh));
                chk("digit_lo", 32'(bus.digit_lo),     32'(e.dl));
                chk("hi_valid", 32'(bus.hi_valid),     32'(e.hv));
                chk("lo_valid", 32'(bus.lo_valid),     32'(e.lv));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        bus.sel_in = 1'b0;
        bus.seg_in = 7'h00;
        cyc(3);
        chk_zero_outputs("reset");
        rst = 1'b0;
        cyc(2);

        // T1: publish after the second matching frame.
        push(14'h035B, 4'd1, 4'd2, 1'b1, 1'b1);
        frame(7'h06, 7'h5B);
        frame(7'h06, 7'h5B);
        drain("t1");

        // T2: steady word and a single glitch frame cause no pulses.
        repeat (10) frame(7'h06, 7'h5B);
        frame(7'h06, 7'h4F);
        frame(7'h06, 7'h5B);
        frame(7'h06, 7'h5B);
        drain("t2");
        chk("t2_word_held", 32'(bus.both7seg_out), 32'h035B);

        // T3: blank hi glyph is illegal, lo shows 8.
        push(14'h007F, 4'd0, 4'd8, 1'b0, 1'b1);
        frame(7'h00, 7'h7F);
        frame(7'h00, 7'h7F);
        drain("t3");

        // T4a: bus settles one cycle after each sel edge; the settled value is captured.
        push(14'h336D, 4'd4, 4'd5, 1'b1, 1'b1);
        repeat (2) begin
            bus.sel_in = 1'b1; bus.seg_in = 7'h49; cyc(1);
            bus.seg_in = 7'h66; cyc(HALF - 1);
            bus.sel_in = 1'b0; bus.seg_in = 7'h12; cyc(1);
            bus.seg_in = 7'h6D; cyc(HALF - 1);
        end
        drain("t4a");

        // T4b: a one-cycle sel pulse restarts settle; its lone lo sample must not break the run.
        push(14'h3E87, 4'd6, 4'd7, 1'b1, 1'b1);
        frame(7'h7D, 7'h07);
        bus.sel_in = 1'b1; cyc(1);
        bus.sel_in = 1'b0; cyc(HALF);
        frame(7'h7D, 7'h07);
        drain("t4b");

        // T5: dead select line raises stale, outputs hold, next edge clears it.
        cyc(950);
        chk("t5_not_stale_yet", 32'(bus.stale), 32'd0);
        cyc(150);
        chk("t5_stale", 32'(bus.stale), 32'd1);
        chk("t5_word_held", 32'(bus.both7seg_out), 32'h3E87);
        bus.sel_in = 1'b1; bus.seg_in = 7'h7D;
        n = 0;
        while (bus.stale !== 1'b0 && n < 8) begin
            cyc(1);
            n++;
        end
        chk("t5_stale_cleared", 32'(bus.stale), 32'd0);
        cyc(HALF - n);
        bus.sel_in = 1'b0; bus.seg_in = 7'h07; cyc(HALF);
        chk("t5_word_after", 32'(bus.both7seg_out), 32'h3E87);

        // T6: mid-frame reset clears everything; the word republishes after fresh frames.
        bus.sel_in = 1'b1; bus.seg_in = 7'h7D;
        cyc(10);
        rst = 1'b1;
        cyc(1);
        chk_zero_outputs("midrst");
        rst = 1'b0;
        push(14'h3E87, 4'd6, 4'd7, 1'b1, 1'b1);
        cyc(HALF - 11);
        bus.sel_in = 1'b0; bus.seg_in = 7'h07; cyc(HALF);
        frame(7'h7D, 7'h07);
        drain("t6");

        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
